parity_tx: RTL
==============

# parity_tx

Parity-encoding transmitter at the write end of the FIFO `top`. It accepts raw `DATA_WIDTH`-bit payloads from an upstream source and inserts a parity bit at `PARITY_BIT`, producing the `DATA_WIDTH+1`-bit words that `top` checks. It drives `top.data_i`/`top.valid_i` and obeys the `top.grant_o` valid/grant handshake. A two-entry skid buffer sustains one word per cycle under back-pressure.

## Interface
- `DATA_WIDTH`, 32, payload width; output word is `DATA_WIDTH+1` bits.
- `EVEN_ODD`, 0, 0 = even parity over the full output word, 1 = odd.
- `PARITY_BIT`, 0, bit position of parity in the output word, 0..`DATA_WIDTH`.
- `CNT_WIDTH`, 16, width of the transfer counter.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: the single clock, rising-edge active.
- `rst_n` in 1: asynchronous reset, active low.
- `data_i` in `DATA_WIDTH`: raw payload from upstream.
- `valid_i` in 1: upstream has a payload.
- `grant_o` out 1: block can accept a payload this cycle.
- `data_o` out `DATA_WIDTH+1`: encoded word, connects to `top.data_i`.
- `valid_o` out 1: `data_o` is valid, connects to `top.valid_i`.
- `grant_i` in 1: downstream accepts, from `top.grant_o`.
- `tx_count_o` out `CNT_WIDTH`: number of words delivered downstream.
- `err_inj_i` in 1: corrupt the parity of the word being accepted. Present only with `PARITY_TX_ERR_INJ_EN`.

## Operation
- Push = `valid_i & grant_o`. Pop = `valid_o & grant_i`. Both are evaluated at the rising edge of `clk`.
- Encoding:
  - Output bits `[PARITY_BIT-1:0]` = payload `[PARITY_BIT-1:0]`.
  - Output bit `PARITY_BIT` = p.
  - Output bits above `PARITY_BIT` = remaining payload bits, shifted up by one.
  - p = `^data_i` when `EVEN_ODD`=0, `~^data_i` when `EVEN_ODD`=1.
- The FSM has states EMPTY, ONE and TWO. It holds a head register (drives `data_o`) and a skid register.
  - EMPTY: push → ONE, head ← encoded word.
  - ONE, push only → TWO, skid ← encoded word.
  - ONE, pop only → EMPTY.
  - ONE, push and pop → ONE, head ← encoded word.
  - ONE, no event → ONE.
  - TWO: no push is possible because `grant_o`=0. Pop → ONE, head ← skid.
- `valid_o` = (state ≠ EMPTY).
- `grant_o` is a register. Its next value is (next_state ≠ TWO).
- `tx_count_o` increments by 1 on each pop and wraps modulo 2^`CNT_WIDTH`.
- Words leave in acceptance order. No word is dropped or duplicated.

## Timing
- Reset values (asserted asynchronously):
  - state = EMPTY
  - `valid_o` = 0
  - `grant_o` = 0
  - `data_o` = 0
  - `tx_count_o` = 0
- `grant_o` rises at the first rising edge after `rst_n` deasserts.
- Latency: a word accepted at edge N appears on `data_o` with `valid_o`=1 after edge N.
- Throughput: one word per cycle while `grant_i`=1.
- While `valid_o`=1 and `grant_i`=0, `data_o` and `valid_o` hold stable.
- `grant_o` falls in the cycle after the second un-popped word is accepted. It rises the cycle after a pop from TWO.
- `valid_i` may drop at any time. A payload is never captured without `grant_o`=1.
- `grant_i` while `valid_o`=0 is ignored: no count and no state change.
- Reset mid-operation discards all buffered words immediately.

## Configuration
- `PARITY_TX_ERR_INJ_EN` defined:
  - Port `err_inj_i` exists.
  - A push with `err_inj_i`=1 stores the word with parity bit inverted.
  - The payload bits are unchanged.
- `PARITY_TX_ERR_INJ_EN` undefined:
  - No `err_inj_i` port.
  - Parity is always correct.

## Structure
- Shared package `parity_pkg` holds:
  - State enum `tx_state_e` (EMPTY, ONE, TWO).
  - Parity polarity constants `PAR_EVEN`=0 and `PAR_ODD`=1.
- Sub-module `parity_enc`: combinational payload-to-word bit insertion plus parity computation. The receiver-side checker reuses it.

## Test plan
All cases use defaults `DATA_WIDTH`=32, `EVEN_ODD`=0, `PARITY_BIT`=0 unless stated.
- Reset: drive `rst_n`=0 mid-cycle → `valid_o`=0, `grant_o`=0, `data_o`=0, `tx_count_o`=0 without waiting for an edge. Release → `grant_o`=1 after the next edge.
- Encode: push 0x1 with `grant_i`=1 → `data_o`=0x3, `valid_o`=1 next cycle. After the pop, `tx_count_o`=1.
  - Same push with `EVEN_ODD`=1 → `data_o`=0x2.
  - Push 0x3 with `EVEN_ODD`=1 → `data_o`=0x7.
- Back-pressure: hold `grant_i`=0 and offer 0xA, 0xB, 0xC back-to-back.
  - 0xA and 0xB are accepted, then `grant_o`=0. 0xC is held upstream.
  - `data_o` stays 0x14.
  - Then set `grant_i`=1 → 0x14, 0x17, 0x18 on consecutive cycles. `tx_count_o`=3.
- Streaming: `valid_i`=`grant_i`=1 for 100 cycles with payload 0..99 → 100 pops, one per cycle, in order. `tx_count_o`=100. `grant_o` never drops.
- Reset in TWO: fill both entries with `grant_i`=0, then pulse `rst_n` low → `valid_o`=0 immediately. No stale word appears after release.
- Error injection (`PARITY_TX_ERR_INJ_EN`): push 0x1 with `err_inj_i`=1 → `data_o`=0x2. Connected to `top`, that word is dropped by the checker and never reaches `top.valid_o`.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity transmitter and its receive-side checker.
package parity_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } tx_state_e;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/parity_enc.sv
// Combinational payload-to-word encoder: inserts a parity bit at PARITY_BIT and shifts
// the payload bits above it up by one. Also used by the receiver-side checker.
module parity_enc
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EVEN_ODD   = PAR_EVEN,
  parameter int PARITY_BIT = 0
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  parity_o,
  output logic [DATA_WIDTH:0]   word_o
);

  localparam logic [DATA_WIDTH:0] LSB_ONE  = {{DATA_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH:0] PAR_MASK = LSB_ONE << PARITY_BIT;
  localparam logic [DATA_WIDTH:0] LOW_MASK = PAR_MASK - LSB_ONE;

  logic [DATA_WIDTH:0] data_ext;

  assign data_ext = {1'b0, data_i};
  assign parity_o = (EVEN_ODD == PAR_ODD) ? ~^data_i : ^data_i;

  // Bits below the parity slot stay put; the rest move up one to make room.
  assign word_o = (data_ext & LOW_MASK)
                | ((data_ext & ~LOW_MASK) << 1)
                | (parity_o ? PAR_MASK : '0);

endmodule

// File: rtl/parity_tx.sv
// Parity-encoding transmitter with a two-entry skid buffer on a valid/grant handshake.
// Optional parity error injection port enabled by defining PARITY_TX_ERR_INJ_EN.
module parity_tx
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EVEN_ODD   = PAR_EVEN,
  parameter int PARITY_BIT = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  output logic [DATA_WIDTH:0]   data_o,
  output logic                  valid_o,
  input  logic                  grant_i,
`ifdef PARITY_TX_ERR_INJ_EN
  input  logic                  err_inj_i,
`endif
  output logic [CNT_WIDTH-1:0]  tx_count_o
);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH:0]   head_q, head_d;
  logic [DATA_WIDTH:0]   skid_q, skid_d;
  logic                  grant_q, grant_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic                  enc_parity;
  logic [DATA_WIDTH:0]   enc_word;
  logic [DATA_WIDTH:0]   word_in;
  logic                  inj;
  logic                  push;
  logic                  pop;

  parity_enc #(
    .DATA_WIDTH (DATA_WIDTH),
    .EVEN_ODD   (EVEN_ODD),
    .PARITY_BIT (PARITY_BIT)
  ) u_enc (
    .data_i   (data_i),
    .parity_o (enc_parity),
    .word_o   (enc_word)
  );

`ifdef PARITY_TX_ERR_INJ_EN
  assign inj = err_inj_i;
`else
  assign inj = 1'b0;
`endif

  always_comb begin
    word_in             = enc_word;
    word_in[PARITY_BIT] = enc_parity ^ inj;
  end

  assign push = valid_i & grant_q;
  assign pop  = (state_q != EMPTY) & grant_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = word_in;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = word_in;
        end else if (push) begin
          state_d = TWO;
          skid_d  = word_in;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Registered grant looks ahead so it is already low when the buffer is full.
    grant_d = (state_d != TWO);
    count_d = count_q + CNT_WIDTH'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      grant_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      grant_q <= grant_d;
      count_q <= count_d;
    end
  end

  assign grant_o    = grant_q;
  assign data_o     = head_q;
  assign valid_o    = (state_q != EMPTY);
  assign tx_count_o = count_q;

endmodule
